// File: rtl/dds_phase_ctrl.sv
// rtl/dds_phase_ctrl.sv - DDS phase accumulator and run controller feeding the waveform ROM stage
module dds_phase_ctrl #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_fword,
    input  logic [7:0]       cfg_poffset,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_ncycles,
    input  logic             start,
    input  logic             stop,
    output logic             en,
    output logic [1:0]       sel,
    output logic [7:0]       addr,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sh_fword;
    logic [7:0]       sh_poffset;
    logic [1:0]       sh_sel;
    logic [CNT_W-1:0] sh_ncycles;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_cnt_inc;
    logic             drain_cnt;

    logic             cfg_hs;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] nxt;
    logic             carry;
    logic             last_period;
    logic             terminate;
    logic [7:0]       start_poffset;

    assign cfg_hs        = cfg_valid & cfg_ready;
    assign sum           = {1'b0, acc} + {1'b0, sh_fword};
    assign nxt           = sum[ACC_W-1:0];
    assign carry         = sum[ACC_W];
    assign per_cnt_inc   = per_cnt + CNT_W'(1);
    assign last_period   = carry && (sh_ncycles != '0) && (per_cnt_inc == sh_ncycles);
    assign terminate     = stop | last_period;
    // A handshake coinciding with start must already govern the first sample.
    assign start_poffset = cfg_hs ? cfg_poffset : sh_poffset;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_RUN;
            S_RUN:   if (terminate) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE:  cfg_ready = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DRAIN: busy      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc        <= '0;
            per_cnt    <= '0;
            drain_cnt  <= 1'b0;
            sh_fword   <= '0;
            sh_poffset <= '0;
            sh_sel     <= '0;
            sh_ncycles <= '0;
            en         <= 1'b0;
            sel        <= '0;
            addr       <= '0;
            wrap       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (cfg_hs) begin
                sh_fword   <= cfg_fword;
                sh_poffset <= cfg_poffset;
                sh_sel     <= cfg_sel;
                sh_ncycles <= cfg_ncycles;
                sel        <= cfg_sel;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        per_cnt <= '0;
                        en      <= 1'b1;
                        addr    <= start_poffset;
                    end
                end
                S_RUN: begin
                    acc  <= nxt;
                    wrap <= carry;
                    if (carry) per_cnt <= per_cnt_inc;
                    // On termination addr keeps the last emitted sample.
                    if (terminate) begin
                        en        <= 1'b0;
                        drain_cnt <= 1'b0;
                    end else begin
                        addr <= nxt[ACC_W-1 -: 8] + sh_poffset;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// tb/tb_dds_phase_ctrl.sv - directed self-checking bench for dds_phase_ctrl
module tb_dds_phase_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_fword;
    logic [7:0]  cfg_poffset;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_ncycles;
    logic        start;
    logic        stop;
    logic        en;
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic        wrap;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    dds_phase_ctrl #(.ACC_W(24), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_fword(cfg_fword), .cfg_poffset(cfg_poffset),
        .cfg_sel(cfg_sel), .cfg_ncycles(cfg_ncycles),
        .start(start), .stop(stop),
        .en(en), .sel(sel), .addr(addr), .wrap(wrap), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input logic [23:0] fw, input logic [7:0] po,
                            input logic [1:0] sl, input logic [15:0] nc);
        cfg_fword   = fw;
        cfg_poffset = po;
        cfg_sel     = sl;
        cfg_ncycles = nc;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int wraps;
        int dones;

        rstn = 1'b0; cfg_valid = 1'b0; cfg_fword = '0; cfg_poffset = '0;
        cfg_sel = '0; cfg_ncycles = '0; start = 1'b0; stop = 1'b0;
        @(negedge clk);

        // Reset values
        tick(); tick();
        chk("rst_en", en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        rstn = 1'b1;
        tick();

        // Single period, unit step
        load_cfg(24'h010000, 8'h00, 2'b01, 16'd1);
        chk("p1_sel_after_cfg", sel, 2'b01);
        pulse_start();
        chk("p1_busy_first", busy, 1);
        for (int i = 0; i < 256; i++) begin
            chk("p1_en", en, 1);
            chk("p1_addr", addr, i);
            tick();
        end
        chk("p1_E_en", en, 0);
        chk("p1_E_wrap", wrap, 1);
        chk("p1_E_addr_hold", addr, 8'hFF);
        chk("p1_E_busy", busy, 1);
        chk("p1_E_done", done, 0);
        tick();
        chk("p1_E1_done", done, 0);
        chk("p1_E1_wrap", wrap, 0);
        chk("p1_E1_busy", busy, 1);
        tick();
        chk("p1_E2_done", done, 1);
        chk("p1_E2_busy", busy, 0);
        chk("p1_E2_cfg_ready", cfg_ready, 1);
        tick();
        chk("p1_E3_done", done, 0);

        // Phase offset wrap, two periods
        load_cfg(24'h020000, 8'hF0, 2'b10, 16'd2);
        pulse_start();
        n = 0; wraps = 0;
        for (int c = 0; c < 400 && en; c++) begin
            chk("p2_addr", addr, (8'hF0 + 2 * n) & 8'hFF);
            n++;
            tick();
            if (wrap) wraps++;
        end
        chk("p2_samples", n, 256);
        chk("p2_wraps", wraps, 2);
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done) dones++;
        end
        chk("p2_dones", dones, 1);

        // Stop during a continuous run, start during drain ignored
        load_cfg(24'h010000, 8'h10, 2'b00, 16'd0);
        pulse_start();
        for (int i = 0; i < 37; i++) tick();
        chk("p3_addr37", addr, 8'h35);
        chk("p3_cfg_ready_run", cfg_ready, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("p3_E_en", en, 0);
        chk("p3_E_addr_hold", addr, 8'h35);
        chk("p3_E_wrap", wrap, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p3_E1_done", done, 0);
        chk("p3_E1_busy", busy, 1);
        tick();
        chk("p3_E2_done", done, 1);
        chk("p3_E2_busy", busy, 0);
        tick();
        chk("p3_E3_busy", busy, 0);
        chk("p3_E3_en", en, 0);

        // Stop coinciding with the terminating carry
        load_cfg(24'h400000, 8'h00, 2'b00, 16'd1);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("p4_addr", addr, i * 64);
            if (i == 3) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        chk("p4_E_en", en, 0);
        chk("p4_E_wrap", wrap, 1);
        chk("p4_E_addr", addr, 8'd192);
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) dones++;
            tick();
        end
        chk("p4_dones", dones, 1);

        // Config handshake and start in the same cycle
        cfg_fword = 24'h010000; cfg_poffset = 8'h5A; cfg_sel = 2'b01; cfg_ncycles = 16'd1;
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        chk("p5_en", en, 1);
        chk("p5_addr", addr, 8'h5A);
        chk("p5_sel", sel, 2'b01);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick(); tick();

        // Reset mid-run, then a clean restart
        load_cfg(24'h010000, 8'h20, 2'b10, 16'd0);
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        chk("p6_addr10", addr, 8'h2A);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("p6_rst_en", en, 0);
        chk("p6_rst_addr", addr, 0);
        chk("p6_rst_sel", sel, 0);
        chk("p6_rst_busy", busy, 0);
        chk("p6_rst_cfg_ready", cfg_ready, 1);
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) dones++;
            tick();
        end
        chk("p6_no_done", dones, 0);
        load_cfg(24'h010000, 8'h33, 2'b10, 16'd1);
        pulse_start();
        chk("p6_restart_en", en, 1);
        chk("p6_restart_addr", addr, 8'h33);
        chk("p6_restart_sel", sel, 2'b10);
        tick();
        chk("p6_restart_addr1", addr, 8'h34);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
